// File: rtl/lap_split_buffer.sv
// Lap capture buffer for the BCD stopwatch.
// Stores {total, split} pairs and hands them to the LCD side FWFT.
//
// Ports:
//   clk, rst, clr     100 Hz timer clock, sync active-high reset, clear
//   lap               lap request level (rising edge captures)
//   up                1 = count-up (split = cur - prev), 0 = count-down
//   minutes..hundredths  current BCD time digits
//   rd_ack            pop head entry (ignored when empty)
//   rd_valid          buffer not empty
//   rd_total/rd_split head entry, packed {min,tens,ones,tenths,hundredths}
//   count, full       occupancy, count == DEPTH
//   overflow          sticky: a capture was dropped while full
module lap_split_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          lap,
    input  logic          up,
    input  logic [3:0]    minutes,
    input  logic [3:0]    tens,
    input  logic [3:0]    ones,
    input  logic [3:0]    tenths,
    input  logic [3:0]    hundredths,
    input  logic          rd_ack,
    output logic          rd_valid,
    output logic [19:0]   rd_total,
    output logic [19:0]   rd_split,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow
);

    logic          lap_d;
    logic          cap;
    logic          do_pop;
    logic          do_wr;
    logic [19:0]   cur;
    logic [19:0]   prev;
    logic [19:0]   split;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [39:0]   mem [DEPTH];

    // Mixed-radix subtraction, digit 0 = hundredths. Digit 3 (tens of
    // seconds) is radix 6. A borrow out of minutes simply drops, which
    // wraps the result modulo 10:00.00.
    function automatic logic [19:0] bcd_sub(input logic [19:0] a,
                                            input logic [19:0] b);
        logic [19:0] r;
        logic        brw;
        logic [4:0]  t;
        logic [4:0]  radix;
        r   = '0;
        brw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            radix = (i == 3) ? 5'd6 : 5'd10;
            t = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, brw};
            brw = t[4];
            if (brw) t = t + radix;
            r[i*4 +: 4] = t[3:0];
        end
        return r;
    endfunction

    assign cur   = {minutes, tens, ones, tenths, hundredths};
    assign split = up ? bcd_sub(cur, prev) : bcd_sub(prev, cur);
    assign cap   = lap & ~lap_d;

    assign rd_valid = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));

    // A pop in the same cycle frees the slot the write needs.
    assign do_pop = rd_ack & rd_valid;
    assign do_wr  = cap & (~full | do_pop);

    assign rd_total = mem[rd_ptr][39:20];
    assign rd_split = mem[rd_ptr][19:0];

    always_ff @(posedge clk) begin
        if (rst) lap_d <= 1'b0;
        else     lap_d <= lap;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            prev     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_pop};
            // prev follows every capture so splits stay right after a drop
            if (cap)           prev     <= cur;
            if (cap && !do_wr) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !rst && !clr) mem[wr_ptr] <= {cur, split};
    end

endmodule

// File: tb/tb_lap_split_buffer.sv
// Self-checking bench for lap_split_buffer.
// Directed lap scenarios plus randomized traffic against a queue model.
module tb_lap_split_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        lap = 1'b0;
    logic        up  = 1'b1;
    logic [3:0]  minutes = '0;
    logic [3:0]  tens = '0;
    logic [3:0]  ones = '0;
    logic [3:0]  tenths = '0;
    logic [3:0]  hundredths = '0;
    logic        rd_ack = 1'b0;
    logic        rd_valid;
    logic [19:0] rd_total;
    logic [19:0] rd_split;
    logic [AW:0] count;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    lap_split_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .lap(lap), .up(up),
        .minutes(minutes), .tens(tens), .ones(ones),
        .tenths(tenths), .hundredths(hundredths),
        .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_total(rd_total), .rd_split(rd_split),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---- reference model: times as integer hundredths mod 10 minutes
    logic [39:0] q[$];
    int          prev_m = 0;
    bit          ovf_m  = 0;
    bit          lapd_m = 0;
    bit          live   = 0;

    function automatic int to_h(input logic [19:0] t);
        return t[19:16]*6000 + t[15:12]*1000 + t[11:8]*100
             + t[7:4]*10 + t[3:0];
    endfunction

    function automatic logic [19:0] from_h(input int h);
        logic [19:0] r;
        r[19:16] = 4'(h / 6000);
        r[15:12] = 4'((h / 1000) % 6);
        r[11:8]  = 4'((h / 100) % 10);
        r[7:4]   = 4'((h / 10) % 10);
        r[3:0]   = 4'(h % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        bit capm;
        int c;
        int s;
        if (rst) begin
            q.delete();
            prev_m = 0;
            ovf_m  = 0;
            lapd_m = 0;
            live   = 1;
        end else begin
            capm   = lap && !lapd_m;
            lapd_m = lap;
            if (clr) begin
                q.delete();
                prev_m = 0;
                ovf_m  = 0;
            end else begin
                if (rd_ack && q.size() > 0) q.delete(0);
                if (capm) begin
                    c = to_h({minutes, tens, ones, tenths, hundredths});
                    s = up ? (c - prev_m + 60000) % 60000
                           : (prev_m - c + 60000) % 60000;
                    if (q.size() < DEPTH) q.push_back({from_h(c), from_h(s)});
                    else ovf_m = 1;
                    prev_m = c;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("m_count", 40'(count), 40'(q.size()));
            chk("m_valid", 40'(rd_valid), 40'(q.size() > 0));
            chk("m_full", 40'(full), 40'(q.size() == DEPTH));
            chk("m_ovf", 40'(overflow), 40'(ovf_m));
            if (q.size() > 0) chk("m_head", {rd_total, rd_split}, q[0]);
        end
    end

    // ---- stimulus helpers
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_t(input logic [19:0] t);
        {minutes, tens, ones, tenths, hundredths} = t;
    endtask

    task automatic do_lap(input logic [19:0] t);
        set_t(t);
        lap = 1'b1;
        tick();
        lap = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        chk("rst_valid", 40'(rd_valid), 40'd0);
        chk("rst_count", 40'(count), 40'd0);
        chk("rst_full", 40'(full), 40'd0);
        chk("rst_ovf", 40'(overflow), 40'd0);

        // up-mode laps
        up = 1'b1;
        do_lap(20'h00125);
        do_lap(20'h00310);
        do_lap(20'h01005);
        chk("up_count", 40'(count), 40'd3);
        chk("up_valid", 40'(rd_valid), 40'd1);
        chk("up_s1", 40'(rd_split), 40'h00125);
        chk("up_t1", 40'(rd_total), 40'h00125);
        pop();
        chk("up_s2", 40'(rd_split), 40'h00185);
        pop();
        chk("up_s3", 40'(rd_split), 40'h00695);
        pop();
        chk("up_empty", 40'(rd_valid), 40'd0);

        // wrap through 10:00.00
        do_reset();
        do_lap(20'h95995);
        pop();
        do_lap(20'h00010);
        chk("wrap_split", 40'(rd_split), 40'h00015);
        chk("wrap_total", 40'(rd_total), 40'h00010);

        // count-down mode
        do_reset();
        up = 1'b0;
        do_lap(20'h50000);
        chk("dn_s1", 40'(rd_split), 40'h50000);
        pop();
        do_lap(20'h45870);
        chk("dn_s2", 40'(rd_split), 40'h00130);
        chk("dn_t2", 40'(rd_total), 40'h45870);
        up = 1'b1;

        // overflow: nine laps, no pops
        do_reset();
        for (int i = 1; i <= 9; i++) do_lap({8'h00, 4'(i), 8'h00});
        chk("ov_count", 40'(count), 40'd8);
        chk("ov_full", 40'(full), 40'd1);
        chk("ov_flag", 40'(overflow), 40'd1);
        pop();
        do_lap(20'h01000);
        chk("ov_count2", 40'(count), 40'd8);
        repeat (7) pop();
        chk("ov_s10", 40'(rd_split), 40'h00100);
        chk("ov_t10", 40'(rd_total), 40'h01000);

        // simultaneous pop + lap while full
        do_reset();
        for (int i = 1; i <= 8; i++) do_lap({8'h00, 4'(i), 8'h00});
        chk("sim_full", 40'(full), 40'd1);
        set_t(20'h00900);
        lap    = 1'b1;
        rd_ack = 1'b1;
        tick();
        lap    = 1'b0;
        rd_ack = 1'b0;
        tick();
        chk("sim_count", 40'(count), 40'd8);
        chk("sim_ovf", 40'(overflow), 40'd0);
        chk("sim_head", 40'(rd_total), 40'h00200);

        // held lap gives one capture
        do_reset();
        set_t(20'h00300);
        lap = 1'b1;
        tick(20);
        lap = 1'b0;
        tick();
        chk("held_count", 40'(count), 40'd1);

        // clear together with a lap edge
        do_reset();
        do_lap(20'h00100);
        do_lap(20'h00200);
        do_lap(20'h00300);
        set_t(20'h00400);
        lap = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        lap = 1'b0;
        tick();
        chk("clr_count", 40'(count), 40'd0);
        chk("clr_valid", 40'(rd_valid), 40'd0);
        do_lap(20'h00250);
        chk("clr_split", 40'(rd_split), 40'h00250);

        // randomized traffic, checked by the model every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            lap    = ($urandom % 3) == 0;
            rd_ack = ($urandom % ((((c / 400) % 2) == 1) ? 2 : 7)) == 0;
            clr    = ($urandom % 120) == 0;
            if (($urandom % 50) == 0) up = ~up;
            minutes    = 4'($urandom % 10);
            tens       = 4'($urandom % 6);
            ones       = 4'($urandom % 10);
            tenths     = 4'($urandom % 10);
            hundredths = 4'($urandom % 10);
            tick();
        end
        lap    = 1'b0;
        rd_ack = 1'b0;
        clr    = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
